sisc_ctrl_mc: RTL and testbench

Parametrised multicycle control unit for the SISC datapath. It sequences every instruction through start, fetch, decode, execute, memory and writeback states and drives all datapath control strobes. Compared with the first-generation controller, it adds:
- generic opcode, mode and status widths;
- evaluated branch conditions;
- short paths for branch and NOOP instructions;
- a data-memory request/acknowledge handshake with wait states;
- a synthesizable HALT state in place of simulator stop;
- a retired-instruction counter.

---
 rtl/sisc_ctrl_mc.sv | 157 +++++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sisc_ctrl_mc.sv
// Multicycle SISC control unit: sequences each instruction through its states and drives the datapath strobes.
// Outputs decode combinationally from state; MEM waits on mem_ack; HALT persists until reset.
module sisc_ctrl_mc #(
    parameter int OP_W     = 4,
    parameter int MM_W     = 4,
    parameter int STAT_W   = 4,
    parameter int IMM_MODE = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [OP_W-1:0]   opcode,
    input  logic [MM_W-1:0]   mm,
    input  logic [STAT_W-1:0] stat,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic [1:0]        alu_op,
    output logic              wb_sel,
    output logic              rb_sel,
    output logic              pc_sel,
    output logic              br_sel,
    output logic              pc_write,
    output logic              pc_rst,
    output logic              ir_load,
    output logic              mem_req,
    output logic              dm_we,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam logic [2:0] S_START0    = 3'd0;
    localparam logic [2:0] S_START1    = 3'd1;
    localparam logic [2:0] S_FETCH     = 3'd2;
    localparam logic [2:0] S_DECODE    = 3'd3;
    localparam logic [2:0] S_EXECUTE   = 3'd4;
    localparam logic [2:0] S_MEM       = 3'd5;
    localparam logic [2:0] S_WRITEBACK = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SWP = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BNR = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       is_lod, is_str, is_swp, is_alu, is_hlt;
    logic       is_br, is_br_pos, is_br_neg, is_rel;
    logic       cond_hit, taken, imm_sel, retire;

    always_comb begin
        is_lod    = (opcode == OP_LOD);
        is_str    = (opcode == OP_STR);
        is_swp    = (opcode == OP_SWP);
        is_alu    = (opcode == OP_ALU);
        is_hlt    = (opcode == OP_HLT);
        is_br_pos = (opcode == OP_BRA) || (opcode == OP_BRR);
        is_br_neg = (opcode == OP_BNE) || (opcode == OP_BNR);
        is_br     = is_br_pos || is_br_neg;
        is_rel    = (opcode == OP_BRR) || (opcode == OP_BNR);
        cond_hit  = |(stat & mm);
        taken     = (is_br_pos && cond_hit) || (is_br_neg && !cond_hit);
        imm_sel   = (mm == MM_W'(IMM_MODE));
    end

    // Unrecognised opcodes fall into the NOOP short path out of DECODE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_START0:  state_nxt = S_START1;
            S_START1:  state_nxt = S_FETCH;
            S_FETCH:   state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_hlt)
                    state_nxt = S_HALT;
                else if (is_lod || is_str || is_swp || is_alu)
                    state_nxt = S_EXECUTE;
                else
                    state_nxt = S_START1;
            end
            S_EXECUTE: state_nxt = (is_lod || is_str) ? S_MEM : S_WRITEBACK;
            S_MEM: begin
                if (mem_ack)
                    state_nxt = is_lod ? S_WRITEBACK : S_START1;
            end
            S_WRITEBACK: state_nxt = S_START1;
            S_HALT:      state_nxt = S_HALT;
            default:     state_nxt = S_START0;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        alu_op   = 2'b00;
        wb_sel   = 1'b0;
        rb_sel   = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        pc_write = 1'b0;
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        mem_req  = 1'b0;
        dm_we    = 1'b0;
        halted   = 1'b0;
        case (state)
            S_START0: pc_rst = 1'b1;
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                if (is_br && taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = is_rel;
                end
            end
            S_EXECUTE, S_MEM, S_WRITEBACK: begin
                // ALU selection stays stable across MEM and WRITEBACK.
                rb_sel = imm_sel;
                alu_op = {!is_alu, imm_sel};
                if (state == S_MEM) begin
                    mem_req = 1'b1;
                    dm_we   = is_str;
                end
                if (state == S_WRITEBACK) begin
                    rf_we  = 1'b1;
                    wb_sel = is_lod;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    // An instruction retires when it returns to START1 or enters HALT.
    assign retire = ((state_nxt == S_START1) &&
                     ((state == S_DECODE) || (state == S_MEM) || (state == S_WRITEBACK))) ||
                    ((state_nxt == S_HALT) && (state != S_HALT));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state     <= S_START0;
            instr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (retire)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Bench for sisc_ctrl_mc: per-instruction expected strobe sequences checked every cycle.
module tb_sisc_ctrl_mc;

    localparam logic [12:0] V_RFWE  = 13'h1000;
    localparam logic [12:0] V_ALU1  = 13'h0800;
    localparam logic [12:0] V_ALU0  = 13'h0400;
    localparam logic [12:0] V_WBSEL = 13'h0200;
    localparam logic [12:0] V_RBSEL = 13'h0100;
    localparam logic [12:0] V_PCSEL = 13'h0080;
    localparam logic [12:0] V_BRSEL = 13'h0040;
    localparam logic [12:0] V_PCWR  = 13'h0020;
    localparam logic [12:0] V_PCRST = 13'h0010;
    localparam logic [12:0] V_IRL   = 13'h0008;
    localparam logic [12:0] V_MREQ  = 13'h0004;
    localparam logic [12:0] V_DMWE  = 13'h0002;
    localparam logic [12:0] V_HALT  = 13'h0001;

    logic        clk = 1'b0;
    logic        rst_f;
    logic [3:0]  opcode, mm, stat;
    logic        mem_ack;

    logic        rf_we, wb_sel, rb_sel, pc_sel, br_sel, pc_write, pc_rst, ir_load, mem_req, dm_we, halted;
    logic [1:0]  alu_op;
    logic [15:0] instr_cnt;
    logic        c2_rf_we, c2_wb_sel, c2_rb_sel, c2_pc_sel, c2_br_sel, c2_pc_write, c2_pc_rst;
    logic        c2_ir_load, c2_mem_req, c2_dm_we, c2_halted;
    logic [1:0]  c2_alu_op;
    logic [1:0]  c2_cnt;

    int          total = 0;
    int          bad = 0;
    logic [12:0] exp_vec;
    int          exp_cnt;
    bit          exp_vld = 1'b0;
    int          cnt_model = 0;
    int          mreq_seen = 0;
    int          irl_seen = 0;

    always #5 clk = ~clk;

    sisc_ctrl_mc dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_ack(mem_ack),
        .rf_we(rf_we), .alu_op(alu_op), .wb_sel(wb_sel), .rb_sel(rb_sel), .pc_sel(pc_sel),
        .br_sel(br_sel), .pc_write(pc_write), .pc_rst(pc_rst), .ir_load(ir_load),
        .mem_req(mem_req), .dm_we(dm_we), .halted(halted), .instr_cnt(instr_cnt)
    );

    sisc_ctrl_mc #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .mem_ack(mem_ack),
        .rf_we(c2_rf_we), .alu_op(c2_alu_op), .wb_sel(c2_wb_sel), .rb_sel(c2_rb_sel),
        .pc_sel(c2_pc_sel), .br_sel(c2_br_sel), .pc_write(c2_pc_write), .pc_rst(c2_pc_rst),
        .ir_load(c2_ir_load), .mem_req(c2_mem_req), .dm_we(c2_dm_we), .halted(c2_halted),
        .instr_cnt(c2_cnt)
    );

    wire [12:0] act  = {rf_we, alu_op, wb_sel, rb_sel, pc_sel, br_sel, pc_write,
                        pc_rst, ir_load, mem_req, dm_we, halted};
    wire [12:0] act2 = {c2_rf_we, c2_alu_op, c2_wb_sel, c2_rb_sel, c2_pc_sel, c2_br_sel,
                        c2_pc_write, c2_pc_rst, c2_ir_load, c2_mem_req, c2_dm_we, c2_halted};

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_vld) begin
            chk("strobes", 32'(act), 32'(exp_vec));
            chk("strobes_cnt2", 32'(act2), 32'(exp_vec));
            chk("instr_cnt", 32'(instr_cnt), exp_cnt % 65536);
            chk("instr_cnt_cnt2", 32'(c2_cnt), exp_cnt % 4);
        end
        if (mem_req) mreq_seen++;
        if (ir_load) irl_seen++;
    end

    function automatic logic rnd_ack();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle at posedge+1 and record what the outputs must be in it.
    task automatic step(input logic [12:0] v, input logic ack);
        mem_ack = ack;
        exp_vec = v;
        exp_cnt = cnt_model;
        exp_vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s, input int w);
        logic [12:0] base;
        logic [12:0] brv;
        bit          taken;
        opcode = op;
        mm     = m;
        stat   = s;
        step(13'h0, rnd_ack());
        step(V_IRL | V_PCWR, rnd_ack());
        base = ((m == 4'd8) ? (V_RBSEL | V_ALU0) : 13'h0) | ((op != 4'd8) ? V_ALU1 : 13'h0);
        case (op)
            4'd4, 4'd5, 4'd6, 4'd7: begin
                taken = (op < 4'd6) ? ((s & m) != 4'd0) : ((s & m) == 4'd0);
                brv   = V_PCWR | V_PCSEL | ((op == 4'd5 || op == 4'd7) ? V_BRSEL : 13'h0);
                step(taken ? brv : 13'h0, rnd_ack());
            end
            4'd1, 4'd2: begin
                step(13'h0, rnd_ack());
                step(base, rnd_ack());
                for (int i = 0; i <= w; i++)
                    step(base | V_MREQ | ((op == 4'd2) ? V_DMWE : 13'h0), (i == w) ? 1'b1 : 1'b0);
                if (op == 4'd1)
                    step(base | V_RFWE | V_WBSEL, rnd_ack());
            end
            4'd3, 4'd8: begin
                step(13'h0, rnd_ack());
                step(base, rnd_ack());
                step(base | V_RFWE, rnd_ack());
            end
            default: step(13'h0, rnd_ack());
        endcase
        cnt_model++;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++)
            step(V_HALT, rnd_ack());
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        cnt_model = 0;
        step(V_PCRST, rnd_ack());
        step(V_PCRST, rnd_ack());
        rst_f = 1'b1;
        step(V_PCRST, rnd_ack());
    endtask

    task automatic mid_mem_reset();
        opcode = 4'd2;
        mm     = 4'd0;
        stat   = 4'd0;
        step(13'h0, 1'b0);
        step(V_IRL | V_PCWR, 1'b0);
        step(13'h0, 1'b0);
        step(V_ALU1, 1'b0);
        mem_ack = 1'b0;
        exp_vld = 1'b0;
        #1;
        chk("mid_mem_req_before", 32'(mem_req), 1);
        rst_f = 1'b0;
        #1;
        chk("mid_mem_req_after", 32'(mem_req), 0);
        chk("mid_mem_pc_rst", 32'(pc_rst), 1);
        chk("mid_mem_cnt", 32'(instr_cnt), 0);
        @(posedge clk);
        #1;
        cnt_model = 0;
        step(V_PCRST, 1'b1);
        rst_f = 1'b1;
        step(V_PCRST, 1'b0);
    endtask

    initial begin
        logic [3:0] op, m;
        int r;
        rst_f = 1'b0; opcode = 4'd0; mm = 4'd0; stat = 4'd0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_pc_rst", 32'(pc_rst), 1);
        chk("reset_strobes", 32'(act), 32'(V_PCRST));
        do_reset();
        chk("start1_idle", 32'(act), 0);

        run_instr(4'd8, 4'd8, 4'd0, 0);
        mreq_seen = 0;
        run_instr(4'd1, 4'd0, 4'd0, 3);
        chk("lod_mem_req_cycles", mreq_seen, 4);
        run_instr(4'd5, 4'b0010, 4'b0010, 0);
        run_instr(4'd6, 4'b0010, 4'b0010, 0);
        chk("cnt_after_four", 32'(instr_cnt), 4);

        run_instr(4'd15, 4'd0, 4'd0, 0);
        irl_seen = 0;
        halt_cycles(20);
        chk("halt_no_fetch", irl_seen, 0);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_cnt", 32'(instr_cnt), 5);

        do_reset();
        for (int i = 0; i < 5; i++)
            run_instr(4'd0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
        chk("noop_cnt_wrap", 32'(c2_cnt), 1);
        chk("noop_cnt_full", 32'(instr_cnt), 5);

        mid_mem_reset();

        for (int n = 0; n < 300; n++) begin
            r  = int'($urandom_range(0, 19));
            op = (r < 16) ? 4'(r) : ((r < 18) ? 4'd1 : 4'd2);
            m  = ($urandom_range(0, 2) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
            run_instr(op, m, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)));
            if (op == 4'd15) begin
                halt_cycles(int'($urandom_range(1, 5)));
                do_reset();
            end
        end

        exp_vld = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
